// File: rtl/xnor_pattern_detector.sv
// ----------------------------------------------------------------------------
// xnor_pattern_detector
//
// Serial pattern matcher. Incoming bits shift into a WIDTH-bit window (newest
// bit at position 0, oldest at WIDTH-1). Each window bit is compared with the
// matching pattern bit using XNOR. The results are AND-reduced to give
// equality. Once WIDTH valid bits have arrived, a one-cycle match pulse is
// emitted on every shift that leaves the window equal to the pattern.
// Overlapping matches count. A saturating counter records the matches.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         shift enable; din is sampled when high
//   din        serial data bit
//   clr        synchronous clear of window, fill, count and flags (beats en)
//   pattern    target pattern, pattern[WIDTH-1] is the oldest bit
//   armed      window holds WIDTH valid bits
//   match      one-cycle pulse, window equals pattern
//   match_cnt  saturating number of matches
//   err_bits   number of window bits differing from pattern
//
// Configuration
//   XNOR_ERRCNT_EN  when defined, err_bits carries the popcount of
//                   (window ^ pattern), updated on each shift while armed.
//                   When undefined, err_bits is tied to zero and no popcount
//                   logic is built.
// ----------------------------------------------------------------------------
module xnor_pattern_detector #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       din,
    input  logic                       clr,
    input  logic [WIDTH-1:0]           pattern,
    output logic                       armed,
    output logic                       match,
    output logic [CNT_W-1:0]           match_cnt,
    output logic [$clog2(WIDTH+1)-1:0] err_bits
);

    localparam int FILL_W = $clog2(WIDTH + 1);
    localparam int ERR_W  = $clog2(WIDTH + 1);

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   win_q;
    logic [WIDTH-1:0]   win_d;
    logic [FILL_W-1:0]  fill_q;
    logic               armed_q;
    logic               armed_d;
    logic               match_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               shift;
    logic               eq;
    logic               lastFill;

    // Equality and armed status are judged on the window as it will be after
    // this edge. This lets the completing bit produce its match pulse on the
    // very next cycle.
    always_comb begin
        shift    = en & ~clr;
        win_d    = shift ? {win_q[WIDTH-2:0], din} : win_q;
        eq       = &(~(win_d ^ pattern));
        lastFill = (fill_q == FILL_W'(WIDTH - 1));
        armed_d  = (state_q == ARMED) | (shift & lastFill);
    end

`ifdef XNOR_ERRCNT_EN
    logic [WIDTH-1:0] diffBits;
    logic [ERR_W-1:0] errPop;
    logic [ERR_W-1:0] err_q;

    // Count the bit positions where the next window disagrees with the pattern.
    always_comb begin
        diffBits = win_d ^ pattern;
        errPop   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            errPop = errPop + ERR_W'(diffBits[i]);
        end
    end

    // The error count follows only real shifts while armed. It stays at zero
    // while the window is still filling, and it holds its value during idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (clr) begin
            err_q <= '0;
        end else if (en) begin
            err_q <= armed_d ? errPop : '0;
        end
    end

    assign err_bits = err_q;
`else
    assign err_bits = '0;
`endif

    // Main control FSM with registered outputs. FILL counts the shifted bits
    // until the window is full. ARMED persists until a clear or reset. The
    // match pulse drops on any cycle without a shift, so one match cannot
    // fire twice. The counter stops at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            win_q   <= '0;
            fill_q  <= '0;
            armed_q <= 1'b0;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else if (clr) begin
            state_q <= FILL;
            win_q   <= '0;
            fill_q  <= '0;
            armed_q <= 1'b0;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else if (en) begin
            win_q   <= win_d;
            armed_q <= armed_d;
            match_q <= armed_d & eq;
            if (state_q == FILL) begin
                fill_q <= fill_q + FILL_W'(1);
                if (lastFill) begin
                    state_q <= ARMED;
                end
            end
            if (armed_d && eq && !(&cnt_q)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else begin
            match_q <= 1'b0;
        end
    end

    assign armed     = armed_q;
    assign match     = match_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_xnor_pattern_detector.sv
// ----------------------------------------------------------------------------
// tb_xnor_pattern_detector
//
// Self-checking bench for xnor_pattern_detector using WIDTH=4 and CNT_W=3.
// A behavioural model keeps a history of the received bits. From that history
// it derives the expected armed, match, count and error outputs. Directed
// scenarios run first, followed by a long randomized run against the model.
// ----------------------------------------------------------------------------
module tb_xnor_pattern_detector;

    localparam int W     = 4;
    localparam int CW    = 3;
    localparam int EW    = $clog2(W + 1);
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          din;
    logic          clr;
    logic [W-1:0]  pattern;
    logic          armed;
    logic          match;
    logic [CW-1:0] match_cnt;
    logic [EW-1:0] err_bits;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model state
    bit histQ[$];
    int mValid;
    bit mArmed;
    bit mMatch;
    int mCnt;
    int mErr;

    xnor_pattern_detector #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .din       (din),
        .clr       (clr),
        .pattern   (pattern),
        .armed     (armed),
        .match     (match),
        .match_cnt (match_cnt),
        .err_bits  (err_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Return the model to its freshly reset state
    task automatic modelReset();
        histQ.delete();
        mValid = 0;
        mArmed = 0;
        mMatch = 0;
        mCnt   = 0;
        mErr   = 0;
    endtask

    // Apply one clock edge to the model. The window is taken from the last W
    // bits received, and the oldest of those bits goes in the MSB.
    task automatic modelStep(input bit e, input bit d, input bit c, input logic [W-1:0] p);
        logic [W-1:0] win;
        int diff;
        if (c) begin
            modelReset();
        end else if (e) begin
            histQ.push_back(d);
            if (histQ.size() > W) void'(histQ.pop_front());
            mValid++;
            mArmed = (mValid >= W);
            win = '0;
            for (int i = 0; i < histQ.size(); i++) win[histQ.size() - 1 - i] = histQ[i];
            diff = 0;
            for (int i = 0; i < W; i++) if (win[i] != p[i]) diff++;
            mMatch = mArmed && (diff == 0);
            if (mMatch && mCnt < CMAX) mCnt++;
`ifdef XNOR_ERRCNT_EN
            mErr = mArmed ? diff : 0;
`else
            mErr = 0;
`endif
        end else begin
            mMatch = 0;
        end
    endtask

    // Drive one cycle of inputs, step the model and settle past the edge
    task automatic tick(input bit e, input bit d, input bit c);
        en  = e;
        din = d;
        clr = c;
        @(posedge clk);
        modelStep(e, d, c, pattern);
        #1;
    endtask

    task automatic applyReset();
        #2 rst_n = 1'b0;
        modelReset();
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        en = 0; din = 0; clr = 0; pattern = '0;
        rst_n = 1'b0;
        modelReset();
        #3;
        nChecks++;
        if (armed !== 1'b0) begin nFails++; $display("[TB] FAIL reset_armed got %b want 0", armed); end
        nChecks++;
        if (match !== 1'b0) begin nFails++; $display("[TB] FAIL reset_match got %b want 0", match); end
        nChecks++;
        if (match_cnt !== '0) begin nFails++; $display("[TB] FAIL reset_cnt got %0d want 0", match_cnt); end
        nChecks++;
        if (err_bits !== '0) begin nFails++; $display("[TB] FAIL reset_err got %0d want 0", err_bits); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [3:0] bits;
        bits = 4'b1011;
        pattern = 4'b1011;
        tick(0, 0, 1);
        for (int i = 3; i >= 0; i--) begin
            tick(1, bits[i], 0);
            nChecks++;
            if (armed !== (i == 0)) begin nFails++; $display("[TB] FAIL basic_armed bit%0d got %b want %b", i, armed, (i == 0)); end
            nChecks++;
            if (match !== (i == 0)) begin nFails++; $display("[TB] FAIL basic_match bit%0d got %b want %b", i, match, (i == 0)); end
        end
        nChecks++;
        if (match_cnt !== 3'd1) begin nFails++; $display("[TB] FAIL basic_cnt got %0d want 1", match_cnt); end
        tick(0, 1, 0);
        nChecks++;
        if (match !== 1'b0) begin nFails++; $display("[TB] FAIL basic_idle_match got %b want 0", match); end
        nChecks++;
        if (match_cnt !== 3'd1) begin nFails++; $display("[TB] FAIL basic_idle_cnt got %0d want 1", match_cnt); end
    endtask

    task automatic test_overlap();
        logic [5:0] bits;
        logic [5:0] want;
        bits = 6'b101010;
        want = 6'b000101;
        pattern = 4'b1010;
        tick(0, 0, 1);
        for (int i = 5; i >= 0; i--) begin
            tick(1, bits[i], 0);
            nChecks++;
            if (match !== want[i]) begin nFails++; $display("[TB] FAIL overlap_match step%0d got %b want %b", 5 - i, match, want[i]); end
        end
        nChecks++;
        if (match_cnt !== 3'd2) begin nFails++; $display("[TB] FAIL overlap_cnt got %0d want 2", match_cnt); end
    endtask

    task automatic test_fill();
        pattern = 4'b0000;
        applyReset();
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0);
            nChecks++;
            if (armed !== 1'b0 || match !== 1'b0) begin nFails++; $display("[TB] FAIL fill_early step%0d got armed=%b match=%b want 0,0", i, armed, match); end
        end
        tick(1, 0, 0);
        nChecks++;
        if (armed !== 1'b1 || match !== 1'b1) begin nFails++; $display("[TB] FAIL fill_complete got armed=%b match=%b want 1,1", armed, match); end
    endtask

    task automatic test_saturate();
        int pulses;
        pulses = 0;
        pattern = 4'b1111;
        tick(0, 0, 1);
        for (int i = 0; i < 12; i++) begin
            tick(1, 1, 0);
            if (match === 1'b1) pulses++;
        end
        nChecks++;
        if (pulses != 9) begin nFails++; $display("[TB] FAIL sat_pulses got %0d want 9", pulses); end
        nChecks++;
        if (match_cnt !== 3'd7) begin nFails++; $display("[TB] FAIL sat_cnt got %0d want 7", match_cnt); end
    endtask

    task automatic test_midstream_reset();
        logic [3:0] bits;
        bits = 4'b1011;
        pattern = 4'b1011;
        tick(0, 0, 1);
        for (int i = 3; i >= 0; i--) tick(1, bits[i], 0);
        tick(1, 1, 0);
        tick(1, 0, 0);
        #2 rst_n = 1'b0;
        modelReset();
        #1;
        nChecks++;
        if (armed !== 1'b0 || match !== 1'b0 || match_cnt !== '0) begin
            nFails++;
            $display("[TB] FAIL midreset_async got armed=%b match=%b cnt=%0d want 0,0,0", armed, match, match_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            tick(1, bits[i], 0);
            nChecks++;
            if (match !== (i == 0) || armed !== (i == 0)) begin
                nFails++;
                $display("[TB] FAIL midreset_refill bit%0d got armed=%b match=%b want %b", i, armed, match, (i == 0));
            end
        end
        nChecks++;
        if (match_cnt !== 3'd1) begin nFails++; $display("[TB] FAIL midreset_cnt got %0d want 1", match_cnt); end
    endtask

    task automatic test_errcnt();
        logic [3:0] bits;
        logic [EW-1:0] wantErr;
        bits = 4'b1001;
`ifdef XNOR_ERRCNT_EN
        wantErr = EW'(2);
`else
        wantErr = '0;
`endif
        pattern = 4'b1111;
        tick(0, 0, 1);
        for (int i = 3; i >= 0; i--) begin
            tick(1, bits[i], 0);
            if (i == 2) begin
                nChecks++;
                if (err_bits !== '0) begin nFails++; $display("[TB] FAIL err_fill got %0d want 0", err_bits); end
            end
        end
        nChecks++;
        if (err_bits !== wantErr || match !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL err_value got err=%0d match=%b want %0d,0", err_bits, match, wantErr);
        end
        pattern = 4'b0000;
        tick(0, 0, 0);
        nChecks++;
        if (err_bits !== wantErr) begin nFails++; $display("[TB] FAIL err_hold got %0d want %0d", err_bits, wantErr); end
        tick(1, 1, 1);
        nChecks++;
        if (armed !== 1'b0 || match !== 1'b0 || match_cnt !== '0 || err_bits !== '0) begin
            nFails++;
            $display("[TB] FAIL err_clr got armed=%b match=%b cnt=%0d err=%0d want all 0", armed, match, match_cnt, err_bits);
        end
    endtask

    task automatic test_random();
        bit e, d, c;
        tick(0, 0, 1);
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 19) == 0) pattern = W'($urandom);
            e = ($urandom_range(0, 3) != 0);
            d = 1'($urandom);
            c = ($urandom_range(0, 39) == 0);
            tick(e, d, c);
            nChecks++;
            if (armed !== mArmed || match !== mMatch || match_cnt !== CW'(mCnt) || err_bits !== EW'(mErr)) begin
                nFails++;
                $display("[TB] FAIL random step%0d got armed=%b match=%b cnt=%0d err=%0d want %b,%b,%0d,%0d",
                         n, armed, match, match_cnt, err_bits, mArmed, mMatch, mCnt, mErr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overlap();
        test_fill();
        test_saturate();
        test_midstream_reset();
        test_errcnt();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
